wb_prefetch_buffer: RTL and testbench
=====================================

WB_PREFETCH_BUFFER -- requirements
Module: wb_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, first prefetch address after reset.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 s_adr_i  in  32  core instruction fetch address (word aligned).
REQ-006 s_cyc_i, s_stb_i  in  1 each  core Wishbone cycle/strobe; held until ack or err.
REQ-007 s_dat_o  out  32  instruction returned to core.
REQ-008 s_ack_o  out  1  registered single-cycle ack to core.
REQ-009 s_err_o  out  1  registered single-cycle bus-error response to core.
REQ-010 m_adr_o  out  32  memory fetch address.
REQ-011 m_cyc_o, m_stb_o  out  1 each  memory Wishbone classic single-beat read request.
REQ-012 m_dat_i  in  32  memory read data, valid with m_ack_i.
REQ-013 m_ack_i, m_err_i  in  1 each  memory completion; err terminates like ack.

Function
REQ-014 SHALL hold a FIFO of DEPTH entries {addr[31:0], data[31:0], err}; count 0..DEPTH.
REQ-015 Memory FSM SHALL have states M_IDLE, M_BUSY, M_DISCARD.
REQ-016 M_IDLE -> M_BUSY when count + 1 <= DEPTH (space reserved for one outstanding read); m_cyc_o=m_stb_o=1, m_adr_o=fetch_pc.
REQ-017 M_BUSY on m_ack_i or m_err_i: push {fetch_pc, m_dat_i, m_err_i}, fetch_pc += 4, -> M_IDLE; at most one outstanding read.
REQ-018 fetch_pc SHALL wrap 32'hFFFFFFFC -> 32'h00000000, no flag.
REQ-019 m_cyc_o, m_stb_o, m_adr_o SHALL stay stable from issue until m_ack_i/m_err_i.
REQ-020 Core request seen when s_cyc_i & s_stb_i & !s_ack_o & !s_err_o.
REQ-021 Hit (count>0, head.addr==s_adr_i): next cycle s_dat_o=head.data, s_ack_o=1 if !head.err else s_err_o=1; pop head; hit latency exactly 1 cycle.
REQ-022 Miss with count==0 and fetch_pc==s_adr_i: no flush; wait until entry pushed, then hit per REQ-021.
REQ-023 Other miss: flush FIFO (count=0), fetch_pc=s_adr_i in same cycle.
REQ-024 Flush while M_BUSY: -> M_DISCARD; returning word SHALL be dropped, never pushed; then M_IDLE and issue at new fetch_pc next cycle.
REQ-025 Flush in M_IDLE: m_adr_o=s_adr_i on the following cycle.
REQ-026 Simultaneous push and pop: both occur; count unchanged.
REQ-027 Push when count==DEPTH SHALL never occur (guaranteed by REQ-016).
REQ-028 s_ack_o and s_err_o SHALL never be 1 together and SHALL be low for at least one cycle between consecutive responses.
REQ-029 Request dropped by core (s_stb_i low) before response: no pop, FIFO kept.

Reset
REQ-030 rst_n low SHALL asynchronously clear: s_ack_o=0, s_err_o=0, s_dat_o=0, m_cyc_o=0, m_stb_o=0, m_adr_o=0, count=0, state=M_IDLE, fetch_pc=RESET_PC.
REQ-031 Reset mid-transaction SHALL abandon the read; a late m_ack_i after release SHALL be ignored unless in M_BUSY.
REQ-032 First m_stb_o after rst_n release SHALL occur within 2 cycles at m_adr_o=RESET_PC.

Verification
REQ-033 Sequential: memory 1-cycle ack, mem[i]=32'h00000013+(i<<20); core fetches 0x0..0x3C -> each s_dat_o equals mem[adr>>2], no duplicates or gaps.
REQ-034 Branch: after 0x0,0x4,0x8 delivered, request 0x40 -> flush, next m_adr_o=0x40, s_dat_o=mem[16].
REQ-035 Flush during outstanding read: memory ack delayed 3 cycles on 0x10, core requests 0x80 -> word from 0x10 never on s_dat_o; next m_adr_o=0x80.
REQ-036 Full: DEPTH=4, core stalled (s_stb_i=0) from reset -> exactly four reads 0x0,0x4,0x8,0xC, then m_stb_o=0; count=4.
REQ-037 Error: m_err_i on 0x8 -> core request 0x8 gets s_err_o=1, s_ack_o=0; request 0xC proceeds with s_ack_o=1.
REQ-038 Async reset while M_BUSY -> all REQ-030 outputs zero immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/wb_prefetch_buffer.sv
// Instruction prefetch buffer between a core Wishbone fetch port and a memory Wishbone port.
// Keeps up to DEPTH prefetched words with a single outstanding memory read.
//
// state     | meaning
// M_IDLE    | no read outstanding; issue when a FIFO slot is free
// M_BUSY    | read outstanding; the returned word will be pushed
// M_DISCARD | read outstanding after a flush; the returned word is dropped
module wb_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_adr_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o,
    output logic        s_err_o,
    output logic [31:0] m_adr_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_err_i
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    localparam logic [1:0] M_IDLE    = 2'd0;
    localparam logic [1:0] M_BUSY    = 2'd1;
    localparam logic [1:0] M_DISCARD = 2'd2;

    logic [31:0]   r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic          r_fifo_err  [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [31:0]   r_fetch_pc;

    logic w_req;
    logic w_head_match;
    logic w_wait;
    logic w_hit;
    logic w_flush;
    logic w_done;
    logic w_push;
    logic w_issue;

    assign w_req        = s_cyc_i & s_stb_i & ~s_ack_o & ~s_err_o;
    assign w_head_match = (r_count != '0) && (r_fifo_addr[r_head] == s_adr_i);
    // Empty FIFO but the requested word is the one being fetched: just wait for it.
    assign w_wait       = (r_count == '0) && (r_fetch_pc == s_adr_i);
    assign w_hit        = w_req & w_head_match;
    assign w_flush      = w_req & ~w_head_match & ~w_wait;
    assign w_done       = m_ack_i | m_err_i;
    assign w_push       = (r_state == M_BUSY) & w_done & ~w_flush;
    assign w_issue      = (r_state == M_IDLE) & (w_flush | (r_count < CNT_FULL));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_tail] <= r_fetch_pc;
            r_fifo_data[r_tail] <= m_dat_i;
            r_fifo_err[r_tail]  <= m_err_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= M_IDLE;
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            m_adr_o    <= 32'h0;
            s_ack_o    <= 1'b0;
            s_err_o    <= 1'b0;
            s_dat_o    <= 32'h0;
        end else begin
            case (r_state)
                M_IDLE: begin
                    if (w_issue) begin
                        r_state <= M_BUSY;
                        m_cyc_o <= 1'b1;
                        m_stb_o <= 1'b1;
                        m_adr_o <= w_flush ? s_adr_i : r_fetch_pc;
                    end
                end
                M_BUSY: begin
                    // A flush coinciding with completion drops the word and needs no discard phase.
                    if (w_done) begin
                        r_state <= M_IDLE;
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                    end else if (w_flush) begin
                        r_state <= M_DISCARD;
                    end
                end
                M_DISCARD: begin
                    if (w_done) begin
                        r_state <= M_IDLE;
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                    end
                end
                default: begin
                    r_state <= M_IDLE;
                    m_cyc_o <= 1'b0;
                    m_stb_o <= 1'b0;
                end
            endcase

            if (w_flush) begin
                r_fetch_pc <= s_adr_i;
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (w_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_hit) begin
                    r_head <= r_head + 1'b1;
                end
                case ({w_push, w_hit})
                    2'b10:   r_count <= r_count + (AW + 1)'(1);
                    2'b01:   r_count <= r_count - (AW + 1)'(1);
                    default: r_count <= r_count;
                endcase
            end

            s_ack_o <= w_hit & ~r_fifo_err[r_head];
            s_err_o <= w_hit &  r_fifo_err[r_head];
            if (w_hit) begin
                s_dat_o <= r_fifo_data[r_head];
            end
        end
    end

endmodule

// File: tb/tb_wb_prefetch_buffer.sv
// Self-checking bench for wb_prefetch_buffer: directed scenarios plus randomized fetch
// streams checked against an address-to-word memory model.
module tb_wb_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_adr_i;
    logic        s_cyc_i;
    logic        s_stb_i;
    logic [31:0] s_dat_o;
    logic        s_ack_o;
    logic        s_err_o;
    logic [31:0] m_adr_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i;
    logic        m_err_i;

    always #5 clk = ~clk;

    wb_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_adr_i (s_adr_i),
        .s_cyc_i (s_cyc_i),
        .s_stb_i (s_stb_i),
        .s_dat_o (s_dat_o),
        .s_ack_o (s_ack_o),
        .s_err_o (s_err_o),
        .m_adr_o (m_adr_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_dat_i (m_dat_i),
        .m_ack_i (m_ack_i),
        .m_err_i (m_err_i)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] issue_log [$];
    logic [31:0] slow_addr = 32'h1;
    bit          rand_lat  = 0;
    bit          rand_err  = 0;
    bit          err_en    = 0;
    logic [31:0] err_addr  = 32'h1;
    bit          watch_en  = 0;
    logic [31:0] bad_word  = 32'h0;
    bit          saw_bad   = 0;
    int          proto_bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 + ((a >> 2) << 20);
    endfunction

    function automatic bit err_of(input logic [31:0] a);
        if (err_en && a == err_addr) return 1'b1;
        if (rand_err && ((a >> 2) % 7) == 5) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory slave: classic single-beat read, latency 0 (1-cycle ack) unless slowed.
    initial begin
        bit busy;
        int wc;
        int lat;
        busy = 0; wc = 0; lat = 0;
        m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            m_ack_i = 1'b0;
            m_err_i = 1'b0;
            if (rst_n && m_cyc_o && m_stb_o) begin
                if (!busy) begin
                    busy = 1;
                    wc   = 0;
                    if (m_adr_o == slow_addr) lat = 3;
                    else if (rand_lat)        lat = int'($urandom_range(0, 2));
                    else                      lat = 0;
                end
                if (wc == lat) begin
                    busy    = 0;
                    m_err_i = err_of(m_adr_o);
                    m_ack_i = !m_err_i;
                    m_dat_i = m_err_i ? 32'hDEAD_BEEF : mem_word(m_adr_o);
                end else begin
                    wc++;
                end
            end else begin
                busy = 0;
            end
        end
    end

    // Issue logger and core-side protocol monitor.
    initial begin
        bit prev_stb;
        bit prev_resp;
        prev_stb = 0; prev_resp = 0;
        forever begin
            @(negedge clk);
            if (m_stb_o && !prev_stb) issue_log.push_back(m_adr_o);
            prev_stb = m_stb_o;
            if (s_ack_o && s_err_o) proto_bad++;
            if ((s_ack_o || s_err_o) && prev_resp) proto_bad++;
            prev_resp = s_ack_o || s_err_o;
            if (watch_en && s_ack_o && s_dat_o == bad_word) saw_bad = 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output bit ack,
                         output bit err, output int lat, output bit ok);
        int cyc;
        s_adr_i = a; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        ok = 0; ack = 0; err = 0; d = 32'h0; cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (s_ack_o || s_err_o) begin
                ok = 1; ack = s_ack_o; err = s_err_o; d = s_dat_o;
                break;
            end
            @(posedge clk);
            #1;
        end
        lat = cyc - 1;
        @(posedge clk);
        #1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
    endtask

    task automatic check_fetch(input logic [31:0] a, output int lat);
        logic [31:0] d;
        bit ack, err, ok;
        bit exp_err;
        exp_err = err_of(a);
        fetch(a, d, ack, err, lat, ok);
        check32($sformatf("resp_in_time@%h", a), 32'(ok), 32'd1);
        check32($sformatf("ack@%h", a), 32'(ack), 32'(!exp_err));
        check32($sformatf("err@%h", a), 32'(err), 32'(exp_err));
        if (ack) check32($sformatf("data@%h", a), d, mem_word(a));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_adr_i = 32'h0;
        repeat (3) @(posedge clk);
        issue_log.delete();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_stb_at(input logic [31:0] a, output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_stb_o && m_adr_o == a) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat;
        int          n0;
        bit          ok;
        logic [31:0] a;

        // Reset values
        rst_n = 1'b0;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_adr_i = 32'h0;
        #3;
        check32("rst_s_ack", 32'(s_ack_o), 32'd0);
        check32("rst_m_stb", 32'(m_stb_o), 32'd0);
        check32("rst_m_adr", m_adr_o, 32'h0);
        do_reset();

        // Core stalled: FIFO fills with exactly DEPTH reads then stops
        repeat (30) begin @(posedge clk); #1; end
        check32("full_reads", 32'(issue_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (issue_log.size() > i) check32($sformatf("full_adr%0d", i), issue_log[i], 32'(i * 4));
        check32("full_stb_low", 32'(m_stb_o), 32'd0);
        check32("full_count", 32'(dut.r_count), 32'd4);

        // Sequential stream 0x0..0x3C; buffered words hit with 1-cycle latency
        for (int i = 0; i < 16; i++) begin
            check_fetch(32'(i * 4), lat);
            if (i < 4) check32($sformatf("hit_latency%0d", i), 32'(lat), 32'd1);
        end
        check32("seq_reads_ge16", 32'(issue_log.size() >= 16), 32'd1);
        for (int i = 0; i < 16; i++)
            if (issue_log.size() > i) check32($sformatf("seq_adr%0d", i), issue_log[i], 32'(i * 4));

        // Branch after 0x0,0x4,0x8
        do_reset();
        check_fetch(32'h0, lat);
        check_fetch(32'h4, lat);
        check_fetch(32'h8, lat);
        n0 = issue_log.size();
        check_fetch(32'h40, lat);
        check32("branch_issue", issue_log.size() > n0 ? issue_log[n0] : 32'hFFFF_FFFF, 32'h40);
        check_fetch(32'h44, lat);

        // Flush with a read outstanding: the old word is discarded
        slow_addr = 32'h10;
        do_reset();
        check_fetch(32'h0, lat);
        wait_stb_at(32'h10, ok);
        check32("slow_read_seen", 32'(ok), 32'd1);
        bad_word = mem_word(32'h10); saw_bad = 0; watch_en = 1;
        n0 = issue_log.size();
        check_fetch(32'h80, lat);
        check32("flush_issue", issue_log.size() > n0 ? issue_log[n0] : 32'hFFFF_FFFF, 32'h80);
        check_fetch(32'h84, lat);
        repeat (10) begin @(posedge clk); #1; end
        check32("discarded_word_unseen", 32'(saw_bad), 32'd0);
        watch_en = 0;
        slow_addr = 32'h1;

        // Bus error on 0x8
        err_en = 1; err_addr = 32'h8;
        do_reset();
        check_fetch(32'h0, lat);
        check_fetch(32'h4, lat);
        check_fetch(32'h8, lat);
        check_fetch(32'hC, lat);
        err_en = 0;

        // Async reset while a read is outstanding
        slow_addr = 32'h8;
        do_reset();
        check_fetch(32'h0, lat);
        check_fetch(32'h4, lat);
        wait_stb_at(32'h8, ok);
        check32("busy_before_reset", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check32("arst_s_ack", 32'(s_ack_o), 32'd0);
        check32("arst_s_err", 32'(s_err_o), 32'd0);
        check32("arst_s_dat", s_dat_o, 32'h0);
        check32("arst_m_cyc", 32'(m_cyc_o), 32'd0);
        check32("arst_m_stb", 32'(m_stb_o), 32'd0);
        check32("arst_m_adr", m_adr_o, 32'h0);
        slow_addr = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ok = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (m_stb_o && !ok) begin
                ok = 1;
                check32("restart_adr", m_adr_o, 32'h0);
            end
        end
        check32("restart_within_2", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        check_fetch(32'h0, lat);

        // Address wrap without flush, then randomized stream with random latency/errors
        rand_lat = 1; rand_err = 1;
        do_reset();
        repeat (12) begin @(posedge clk); #1; end
        n0 = issue_log.size();
        check_fetch(32'hFFFF_FFF8, lat);
        check_fetch(32'hFFFF_FFFC, lat);
        check_fetch(32'h0, lat);
        check32("wrap_adr0", issue_log.size() > n0     ? issue_log[n0]     : 32'h1, 32'hFFFF_FFF8);
        check32("wrap_adr1", issue_log.size() > n0 + 1 ? issue_log[n0 + 1] : 32'h1, 32'hFFFF_FFFC);
        check32("wrap_adr2", issue_log.size() > n0 + 2 ? issue_log[n0 + 2] : 32'h1, 32'h0);
        a = 32'h0;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) < 7) a = a + 32'd4;
            else                          a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            check_fetch(a, lat);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        rand_lat = 0; rand_err = 0;

        check32("resp_protocol", 32'(proto_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
